// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad row-strobe scanner with frame-based debounce.
// Drives one-hot rows, samples columns at the end of each dwell, picks the
// lowest row/column hit per frame, debounces across whole frames and reports
// a registered key code with press/release pulses and a held level.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 3,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int PHONE_MAP      = 1,
    parameter int KEY_W          = ((NUM_ROWS * NUM_COLS) > 16) ? $clog2(NUM_ROWS * NUM_COLS) : 4,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_drv,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    output logic                key_held,
    output logic                key_release
);

    localparam int NKEYS = NUM_ROWS * NUM_COLS;
    localparam int IDX_W = $clog2(NKEYS);
    localparam int RW    = $clog2(NUM_ROWS);
    localparam int CW    = $clog2(NUM_COLS);
    localparam int DW    = $clog2(SCAN_DIV);
    localparam int DBW   = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic {IDLE, HELD} state_t;

    state_t           state;
    logic [DW-1:0]    dwell;
    logic [RW-1:0]    row;
    logic             frm_hit;
    logic [IDX_W-1:0] frm_idx;
    logic             cand_hit;
    logic [IDX_W-1:0] cand_idx;
    logic [DBW-1:0]   stab_cnt;

`ifdef KEYPAD_REPEAT_EN
    logic [15:0]      rep_cnt;
    logic             rep_first;
`endif

    logic             samp;
    logic             frame_end;
    logic [CW-1:0]    col_pos;
    logic [IDX_W-1:0] row_idx;
    logic             res_hit;
    logic [IDX_W-1:0] res_idx;
    logic             same;
    logic [DBW-1:0]   cnt_nxt;
    logic             press_ok;
    logic             rel_ok;

    // Legacy phone layout or plain linear index.
    function automatic logic [KEY_W-1:0] map_code(input logic [IDX_W-1:0] idx);
        map_code = KEY_W'(idx);
        if (PHONE_MAP != 0) begin
            if (idx == IDX_W'(9))       map_code = KEY_W'(4'hA);
            else if (idx == IDX_W'(10)) map_code = '0;
            else if (idx == IDX_W'(11)) map_code = KEY_W'(4'hB);
            else                        map_code = KEY_W'(idx) + KEY_W'(1);
        end
    endfunction

    assign samp      = (dwell == DW'(SCAN_DIV - 1));
    assign frame_end = samp && (row == RW'(NUM_ROWS - 1));

    // Lowest set column wins within the current row.
    always_comb begin
        col_pos = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--)
            if (col_in[c]) col_pos = CW'(c);
    end

    // Frame result including this sample; earlier rows take priority.
    always_comb begin
        row_idx  = IDX_W'(row) * IDX_W'(NUM_COLS) + IDX_W'(col_pos);
        res_hit  = frm_hit | (|col_in);
        res_idx  = frm_hit ? frm_idx : ((|col_in) ? row_idx : '0);
        same     = (res_hit == cand_hit) && (res_idx == cand_idx);
        cnt_nxt  = same ? ((stab_cnt == DBW'(DEBOUNCE_SCANS)) ? stab_cnt : stab_cnt + DBW'(1))
                        : DBW'(1);
        press_ok = frame_end && res_hit  && (cnt_nxt == DBW'(DEBOUNCE_SCANS));
        rel_ok   = frame_end && !res_hit && (cnt_nxt == DBW'(DEBOUNCE_SCANS));
    end

    // Dwell counter and one-hot row rotation; row moves the cycle after sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell   <= '0;
            row     <= '0;
            row_drv <= NUM_ROWS'(1);
        end else if (samp) begin
            dwell   <= '0;
            row     <= frame_end ? '0 : row + RW'(1);
            row_drv <= {row_drv[NUM_ROWS-2:0], row_drv[NUM_ROWS-1]};
        end else begin
            dwell   <= dwell + DW'(1);
        end
    end

    // First hit of the frame is latched and cleared at frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_hit <= 1'b0;
            frm_idx <= '0;
        end else if (frame_end) begin
            frm_hit <= 1'b0;
            frm_idx <= '0;
        end else if (samp && !frm_hit && (|col_in)) begin
            frm_hit <= 1'b1;
            frm_idx <= row_idx;
        end
    end

    // Debounce: count consecutive identical frame results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_hit <= 1'b0;
            cand_idx <= '0;
            stab_cnt <= '0;
        end else if (frame_end) begin
            cand_hit <= res_hit;
            cand_idx <= res_idx;
            stab_cnt <= cnt_nxt;
        end
    end

    // Press/release FSM with registered outputs; decisions land one cycle after frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            key_code    <= '1;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
`endif
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                IDLE: if (press_ok) begin
                    state     <= HELD;
                    key_code  <= map_code(res_idx);
                    key_valid <= 1'b1;
                    key_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt   <= '0;
                    rep_first <= 1'b1;
`endif
                end
                HELD: if (rel_ok) begin
                    state       <= IDLE;
                    key_release <= 1'b1;
                    key_held    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt     <= '0;
                    rep_first   <= 1'b1;
                end else if (frame_end && res_hit) begin
                    // Repeat only counts frames where a key is actually seen.
                    if (rep_cnt + 16'd1 == (rep_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_RATE))) begin
                        key_valid <= 1'b1;
                        rep_cnt   <= '0;
                        rep_first <= 1'b0;
                    end else begin
                        rep_cnt   <= rep_cnt + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: 4x3 keypad, SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle frames).
// u1 uses the phone map, u0 the linear index; both see the same key matrix.
module tb_keypad_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0][2:0] keys = '0;
    logic [2:0] col1, col0;
    logic [3:0] row1, row0;
    logic [3:0] code1, code0;
    logic v1, v0, h1, h0, r1, r0;

    keypad_scanner #(.NUM_ROWS(4), .NUM_COLS(3), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
        .PHONE_MAP(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)) u1 (
        .clk(clk), .rst_n(rst_n), .col_in(col1), .row_drv(row1), .key_code(code1),
        .key_valid(v1), .key_held(h1), .key_release(r1));

    keypad_scanner #(.NUM_ROWS(4), .NUM_COLS(3), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
        .PHONE_MAP(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)) u0 (
        .clk(clk), .rst_n(rst_n), .col_in(col0), .row_drv(row0), .key_code(code0),
        .key_valid(v0), .key_held(h0), .key_release(r0));

    // Keypad matrix model: a pressed key shorts its row strobe onto its column.
    always_comb begin
        col1 = '0;
        col0 = '0;
        for (int r = 0; r < 4; r++) begin
            if (row1[r]) col1 = col1 | keys[r];
            if (row0[r]) col0 = col0 | keys[r];
        end
    end

    int errors = 0, checks = 0;
    int tcyc = 0, t0 = 0;
    int nv1 = 0, nv0 = 0, nr1 = 0;
    int bv1 = 0, bv0 = 0, br1 = 0, sb = 0;
    int stamps[$];

    always @(posedge clk) tcyc++;

    // Pulse counters and press timestamps, sampled mid-cycle.
    always @(negedge clk) begin
        if (v1 === 1'b1) begin nv1++; stamps.push_back(tcyc); end
        if (v0 === 1'b1) nv0++;
        if (r1 === 1'b1) nr1++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset both DUTs with key matrix k applied; cycle 0 of frame 0 follows.
    task automatic do_reset(input logic [3:0][2:0] k);
        @(negedge clk);
        rst_n = 1'b0;
        keys  = k;
        wait_cyc(2);
        rst_n = 1'b1;
        t0 = tcyc; bv1 = nv1; bv0 = nv0; br1 = nr1; sb = stamps.size();
    endtask

    task automatic test_reset;
        do_reset('0);
        wait_cyc(6);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (row1 !== 4'b0001) begin errors++; $display("FAIL reset_row1: got %b want 0001", row1); end
        checks++; if (row0 !== 4'b0001) begin errors++; $display("FAIL reset_row0: got %b want 0001", row0); end
        checks++; if (code1 !== 4'hF) begin errors++; $display("FAIL reset_code: got %h want f", code1); end
        checks++; if ({v1, h1, r1, v0, h0, r0} !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b want 000000", {v1, h1, r1, v0, h0, r0}); end
    endtask

    task automatic test_press;
        logic [3:0][2:0] k = '0;
        k[2][1] = 1'b1;
        do_reset(k);
        wait_cyc(47);
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL press_early: got %b want 0", v1); end
        wait_cyc(1);
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL press_valid: got %b want 1", v1); end
        checks++; if (code1 !== 4'h8) begin errors++; $display("FAIL press_code_phone: got %h want 8", code1); end
        checks++; if (code0 !== 4'h7) begin errors++; $display("FAIL press_code_linear: got %h want 7", code0); end
        checks++; if (h1 !== 1'b1) begin errors++; $display("FAIL press_held: got %b want 1", h1); end
        wait_cyc(1);
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL press_pulse_width: got %b want 0", v1); end
        wait_cyc(47);
        keys = '0;
        wait_cyc(47);
        checks++; if ({r1, h1} !== 2'b01) begin errors++; $display("FAIL release_early: got %b want 01", {r1, h1}); end
        wait_cyc(1);
        checks++; if ({r1, h1, v1} !== 3'b100) begin errors++; $display("FAIL release_pulse: got %b want 100", {r1, h1, v1}); end
        checks++; if (code1 !== 4'h8) begin errors++; $display("FAIL release_code_kept: got %h want 8", code1); end
        wait_cyc(1);
        checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL release_width: got %b want 0", r1); end
        checks++; if (nv1 - bv1 != 1 || nv0 - bv0 != 1 || nr1 - br1 != 1)
            begin errors++; $display("FAIL press_counts: got v1=%0d v0=%0d r=%0d want 1 1 1", nv1 - bv1, nv0 - bv0, nr1 - br1); end
    endtask

    task automatic test_code_corner;
        logic [3:0][2:0] k = '0;
        k[3][2] = 1'b1;
        do_reset(k);
        wait_cyc(48);
        checks++; if ({v1, code1} !== 5'h1B) begin errors++; $display("FAIL corner_phone: got v=%b code=%h want v=1 code=b", v1, code1); end
        checks++; if (code0 !== 4'd11) begin errors++; $display("FAIL corner_linear: got %0d want 11", code0); end
    endtask

    task automatic test_bounce;
        logic [3:0][2:0] k = '0;
        k[0][1] = 1'b1;
        do_reset('0);
        for (int f = 0; f < 4; f++) begin
            keys = (f % 2 == 0) ? k : '0;
            wait_cyc(16);
        end
        keys = k;
        wait_cyc(47);
        checks++; if (nv1 - bv1 != 0 || v1 !== 1'b0) begin errors++; $display("FAIL bounce_early: got count=%0d v=%b want 0 0", nv1 - bv1, v1); end
        wait_cyc(1);
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL bounce_valid: got %b want 1", v1); end
        checks++; if ({code1, code0} !== 8'h21) begin errors++; $display("FAIL bounce_code: got %h want 21", {code1, code0}); end
    endtask

    task automatic test_multi;
        logic [3:0][2:0] k = '0;
        k[1][2] = 1'b1;
        k[3][0] = 1'b1;
        do_reset(k);
        wait_cyc(48);
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL multi_valid: got %b want 1", v1); end
        checks++; if ({code1, code0} !== 8'h65) begin errors++; $display("FAIL multi_code: got %h want 65", {code1, code0}); end
        keys[0][0] = 1'b1;
        wait_cyc(80);
        checks++; if (nv1 - bv1 != 1) begin errors++; $display("FAIL multi_no_extra: got %0d want 1", nv1 - bv1); end
        checks++; if ({h1, code1} !== 5'h16) begin errors++; $display("FAIL multi_held_code: got %h want 16", {h1, code1}); end
        keys = '0;
        wait_cyc(48);
        checks++; if ({r1, h1} !== 2'b10) begin errors++; $display("FAIL multi_release: got %b want 10", {r1, h1}); end
    endtask

    task automatic test_reset_held;
        int brel;
        logic [3:0][2:0] k = '0;
        k[2][1] = 1'b1;
        do_reset(k);
        wait_cyc(48);
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL rh_first_valid: got %b want 1", v1); end
        wait_cyc(10);
        brel = nr1;
        rst_n = 1'b0;
        #1;
        checks++; if ({h1, r1, code1} !== 6'h0F) begin errors++; $display("FAIL rh_cleared: got %h want 0f", {h1, r1, code1}); end
        @(negedge clk);
        rst_n = 1'b1;
        bv1 = nv1;
        wait_cyc(47);
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rh_early: got %b want 0", v1); end
        wait_cyc(1);
        checks++; if ({v1, code1} !== 5'h18) begin errors++; $display("FAIL rh_rereport: got %h want 18", {v1, code1}); end
        checks++; if (nr1 != brel) begin errors++; $display("FAIL rh_no_release: got %0d want %0d", nr1, brel); end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat;
        int exp_t[6] = '{48, 112, 144, 176, 208, 240};
        logic [3:0][2:0] k = '0;
        k[2][1] = 1'b1;
        do_reset(k);
        wait_cyc(256);
        keys = '0;
        wait_cyc(64);
        checks++; if (stamps.size() - sb != 6) begin errors++; $display("FAIL repeat_count: got %0d want 6", stamps.size() - sb); end
        for (int i = 0; i < 6; i++) begin
            if (sb + i < stamps.size()) begin
                checks++;
                if (stamps[sb + i] - t0 != exp_t[i]) begin errors++; $display("FAIL repeat_time%0d: got %0d want %0d", i, stamps[sb + i] - t0, exp_t[i]); end
            end
        end
        checks++; if (nr1 - br1 != 1 || code1 !== 4'h8) begin errors++; $display("FAIL repeat_release: got r=%0d code=%h want 1 8", nr1 - br1, code1); end
    endtask
`else
    task automatic test_no_repeat;
        logic [3:0][2:0] k = '0;
        k[2][1] = 1'b1;
        do_reset(k);
        wait_cyc(320);
        checks++; if (nv1 - bv1 != 1) begin errors++; $display("FAIL no_repeat: got %0d want 1", nv1 - bv1); end
        checks++; if (h1 !== 1'b1) begin errors++; $display("FAIL no_repeat_held: got %b want 1", h1); end
    endtask
`endif

    initial begin
        test_reset;
        test_press;
        test_code_corner;
        test_bounce;
        test_multi;
        test_reset_held;
`ifdef KEYPAD_REPEAT_EN
        test_repeat;
`else
        test_no_repeat;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
